// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one combinational adder between two valid/ready requesters with round-robin grant.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module adder_arbiter #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  rsp0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] adder_src_a,
  output logic [DATA_WIDTH-1:0] adder_src_b,
  input  logic [DATA_WIDTH-1:0] adder_dst,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic                  owner_q, owner_d, last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;
  logic                  grant, accept, rsp_fire;
  // On a tie the requester that did not win last time gets the grant.
  assign grant    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign accept   = (state_q == IDLE) && (req0_valid || req1_valid);
  assign rsp_fire = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
  assign req0_ready  = accept && !grant;
  assign req1_ready  = accept && grant;
  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) && owner_q;
  assign rsp0_data   = result_q;
  assign rsp1_data   = result_q;
  assign adder_src_a = op_a_q;
  assign adder_src_b = op_b_q;
  assign busy        = state_q != IDLE;
  assign op_count    = op_count_q;
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d      = EXEC;
        op_a_d       = grant ? req1_a : req0_a;
        op_b_d       = grant ? req1_b : req0_b;
        owner_d      = grant;
        last_grant_d = grant;
      end
      EXEC: begin
        result_d = adder_dst;
        state_d  = RESP;
      end
      RESP: if (rsp_fire) begin
        state_d    = IDLE;
        op_count_d = op_count_q + CNT_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_count_q   <= op_count_d;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed checks of grant order, latency, backpressure, wrap and async reset.
module tb_adder_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp0_data, rsp1_data, adder_src_a, adder_src_b, adder_dst;
  logic [3:0]  op_count;
  int          n_checks = 0, n_fail = 0;

  adder_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .adder_src_a(adder_src_a), .adder_src_b(adder_src_b), .adder_dst(adder_dst),
    .busy(busy), .op_count(op_count)
  );

  // Stand-in for the shared adder: carry discarded.
  assign adder_dst = adder_src_a + adder_src_b;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full operation on requester `who`, assuming it wins in the current IDLE cycle.
  task automatic do_op(input logic who, input logic [31:0] a, input logic [31:0] b);
    if (who) begin req1_valid = 1; req1_a = a; req1_b = b; rsp1_ready = 1; end
    else     begin req0_valid = 1; req0_a = a; req0_b = b; rsp0_ready = 1; end
    #1;
    check("op_ready", who ? req1_ready : req0_ready, 1);
    tick;
    req0_valid = 0;
    req1_valid = 0;
    tick;
    check("op_valid", who ? rsp1_valid : rsp0_valid, 1);
    check("op_data", who ? rsp1_data : rsp0_data, a + b);
    tick;
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp0v", rsp0_valid, 0);
    check("rst_rsp1v", rsp1_valid, 0);
    check("rst_cnt", op_count, 0);
    check("rst_src_a", adder_src_a, 0);
    tick;
    rst_n = 1;
    // Single request
    req0_valid = 1; req0_a = 1; req0_b = 8; rsp0_ready = 1;
    #1;
    check("s_req0_ready", req0_ready, 1);
    check("s_req1_ready", req1_ready, 0);
    tick;
    req0_valid = 0;
    check("s_exec_busy", busy, 1);
    check("s_exec_src_a", adder_src_a, 1);
    check("s_exec_src_b", adder_src_b, 8);
    check("s_exec_rsp0v", rsp0_valid, 0);
    check("s_exec_ready", req0_ready, 0);
    tick;
    check("s_rsp0v", rsp0_valid, 1);
    check("s_rsp0d", rsp0_data, 9);
    check("s_rsp1v", rsp1_valid, 0);
    tick;
    check("s_cnt", op_count, 1);
    check("s_idle", busy, 0);
    check("s_rsp1v_end", rsp1_valid, 0);
    // Contention from reset: 0 first, then 1
    rst_n = 0;
    #1;
    check("c_rst_cnt", op_count, 0);
    tick;
    rst_n = 1;
    req0_valid = 1; req0_a = 9; req0_b = 6; rsp0_ready = 1;
    req1_valid = 1; req1_a = 3; req1_b = 4; rsp1_ready = 1;
    #1;
    check("c_g0_r0", req0_ready, 1);
    check("c_g0_r1", req1_ready, 0);
    tick;
    tick;
    check("c_rsp0d", rsp0_data, 15);
    check("c_rsp0v", rsp0_valid, 1);
    check("c_rsp1v", rsp1_valid, 0);
    tick;
    check("c_g1_r1", req1_ready, 1);
    check("c_g1_r0", req0_ready, 0);
    tick;
    req0_valid = 0; req1_valid = 0;
    tick;
    check("c_rsp1v", rsp1_valid, 1);
    check("c_rsp1d", rsp1_data, 7);
    check("c_rsp0v_off", rsp0_valid, 0);
    tick;
    check("c_cnt", op_count, 2);
    // Backpressure on requester 1 while requester 0 waits
    req1_valid = 1; req1_a = 10; req1_b = 20; rsp1_ready = 0; rsp0_ready = 1;
    #1;
    check("b_req1_ready", req1_ready, 1);
    tick;
    req1_valid = 0;
    req0_valid = 1; req0_a = 5; req0_b = 5;
    tick;
    for (int i = 0; i < 5; i++) begin
      check("b_hold_v", rsp1_valid, 1);
      check("b_hold_d", rsp1_data, 30);
      check("b_hold_r0", req0_ready, 0);
      tick;
    end
    rsp1_ready = 1;
    #1;
    check("b_fire_r0", req0_ready, 0);
    tick;
    check("b_cnt", op_count, 3);
    check("b_idle_r0", req0_ready, 1);
    tick;
    req0_valid = 0;
    tick;
    check("b_rsp0d", rsp0_data, 10);
    tick;
    check("b_cnt2", op_count, 4);
    // Data wrap, then counter wrap at 17 operations
    do_op(0, 32'hFFFF_FFFF, 32'd2);
    check("w_cnt5", op_count, 5);
    for (int i = 0; i < 12; i++) do_op(i[0], 32'(i * 3), 32'd100);
    check("w_cnt_wrap", op_count, 1);
    // Reset during EXEC
    req0_valid = 1; req0_a = 2; req0_b = 3; rsp0_ready = 1;
    tick;
    req0_valid = 0;
    check("r_exec_busy", busy, 1);
    #2;
    rst_n = 0;
    #1;
    check("r_busy", busy, 0);
    check("r_rsp0v", rsp0_valid, 0);
    check("r_cnt", op_count, 0);
    check("r_src_a", adder_src_a, 0);
    tick;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      check("r_nostale", {31'd0, rsp0_valid | rsp1_valid}, 0);
      tick;
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    check("r_tie_r0", req0_ready, 1);
    check("r_tie_r1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    // Withdrawn request during RESP
    req0_valid = 1; req0_a = 7; req0_b = 7; rsp0_ready = 0;
    tick;
    req0_valid = 0;
    tick;
    req1_valid = 1; req1_a = 1; req1_b = 1;
    #1;
    check("wd_r1_resp", req1_ready, 0);
    tick;
    req1_valid = 0;
    check("wd_rsp0d", rsp0_data, 14);
    rsp0_ready = 1;
    tick;
    check("wd_idle_r1", req1_ready, 0);
    tick;
    check("wd_busy", busy, 0);
    check("wd_cnt", op_count, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
